// File: rtl/rv_mc_fsm.sv
// Multicycle RV32I main controller: sequences fetch, decode, ALU, memory and writeback per instruction.
// Moore-decoded strobes (FETCH writes gated by mem_ready_i), plus a wrapping retired-instruction counter.
module rv_mc_fsm #(
   parameter int unsigned RESET_VEC_WAIT = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [6:0]  opcode_i,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        addr_sel_o,
   output logic        instr_we_o,
   output logic        pc_we_o,
   output logic        rd_we_o,
   output logic [1:0]  alu_src_a_o,
   output logic [1:0]  alu_src_b_o,
   output logic [1:0]  result_sel_o,
   output logic [1:0]  alu_op_o,
   output logic        illegal_instr_o,
   output logic [31:0] instret_o
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [3:0] IDLE_LAST = 4'(RESET_VEC_WAIT - 1);

   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_OLDPC = 2'd1;
   localparam logic [1:0] SRC_A_RS1   = 2'd2;
   localparam logic [1:0] SRC_B_RS2   = 2'd0;
   localparam logic [1:0] SRC_B_IMM   = 2'd1;
   localparam logic [1:0] SRC_B_FOUR  = 2'd2;
   localparam logic [1:0] RES_ALUOUT  = 2'd0;
   localparam logic [1:0] RES_MEM     = 2'd1;
   localparam logic [1:0] RES_ALU     = 2'd2;
   localparam logic [1:0] RES_UIMM    = 2'd3;
   localparam logic [1:0] ALU_ADD     = 2'b00;
   localparam logic [1:0] ALU_SUB     = 2'b01;
   localparam logic [1:0] ALU_FUNCT   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BEQ,
      S_LUI,
      S_TRAP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idle_cnt_q, idle_cnt_d;
   logic [31:0] instret_q, instret_d;
   logic        retire;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idle_cnt_q <= 4'd0;
         instret_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         instret_q  <= instret_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      idle_cnt_d      = idle_cnt_q;
      retire          = 1'b0;
      mem_req_o       = 1'b0;
      mem_we_o        = 1'b0;
      addr_sel_o      = 1'b0;
      instr_we_o      = 1'b0;
      pc_we_o         = 1'b0;
      rd_we_o         = 1'b0;
      alu_src_a_o     = SRC_A_PC;
      alu_src_b_o     = SRC_B_RS2;
      result_sel_o    = RES_ALUOUT;
      alu_op_o        = ALU_ADD;
      illegal_instr_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (idle_cnt_q == IDLE_LAST) begin
               idle_cnt_d = 4'd0;
               state_d    = S_FETCH;
            end else begin
               idle_cnt_d = idle_cnt_q + 4'd1;
            end
         end
         S_FETCH: begin
            // PC+4 is written back in the same cycle the instruction word lands.
            mem_req_o    = 1'b1;
            addr_sel_o   = 1'b0;
            alu_src_a_o  = SRC_A_PC;
            alu_src_b_o  = SRC_B_FOUR;
            alu_op_o     = ALU_ADD;
            result_sel_o = RES_ALU;
            instr_we_o   = mem_ready_i;
            pc_we_o      = mem_ready_i;
            if (mem_ready_i) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target is precomputed here regardless of opcode.
            alu_src_a_o = SRC_A_OLDPC;
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = ALU_ADD;
            case (opcode_i)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BEQ:       state_d = S_BEQ;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = ALU_ADD;
            state_d     = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req_o  = 1'b1;
            addr_sel_o = 1'b1;
            if (mem_ready_i) begin
               state_d = S_MEMWB;
            end
         end
         S_MEMWB: begin
            rd_we_o      = 1'b1;
            result_sel_o = RES_MEM;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            addr_sel_o = 1'b1;
            if (mem_ready_i) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC_R: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_RS2;
            alu_op_o    = ALU_FUNCT;
            state_d     = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a_o = SRC_A_RS1;
            alu_src_b_o = SRC_B_IMM;
            alu_op_o    = ALU_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            rd_we_o      = 1'b1;
            result_sel_o = RES_ALUOUT;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a_o  = SRC_A_RS1;
            alu_src_b_o  = SRC_B_RS2;
            alu_op_o     = ALU_SUB;
            result_sel_o = RES_ALUOUT;
            pc_we_o      = zero_i;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_LUI: begin
            rd_we_o      = 1'b1;
            result_sel_o = RES_UIMM;
            retire       = 1'b1;
            state_d      = S_FETCH;
         end
         S_TRAP: begin
            illegal_instr_o = 1'b1;
            state_d         = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Natural 32-bit wrap; no overflow indication.
   assign instret_d = retire ? instret_q + 32'd1 : instret_q;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_rv_mc_fsm.sv
// Randomised bench for rv_mc_fsm: a per-instruction model predicts cycle count, strobe counts and instret,
// while a responsive memory inserts wait states and checks request stability.
module tb_rv_mc_fsm;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [6:0]  opcode_i = 7'd0;
   logic        zero_i = 1'b0;
   logic        mem_ready_i = 1'b0;
   logic        mem_req_o, mem_we_o, addr_sel_o, instr_we_o, pc_we_o, rd_we_o;
   logic [1:0]  alu_src_a_o, alu_src_b_o, result_sel_o, alu_op_o;
   logic        illegal_instr_o;
   logic [31:0] instret_o;

   int          errs = 0;
   int          checks = 0;
   logic [31:0] model_instret = 32'd0;

   rv_mc_fsm #(.RESET_VEC_WAIT(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .zero_i(zero_i),
      .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .addr_sel_o(addr_sel_o), .instr_we_o(instr_we_o), .pc_we_o(pc_we_o),
      .rd_we_o(rd_we_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .result_sel_o(result_sel_o), .alu_op_o(alu_op_o),
      .illegal_instr_o(illegal_instr_o), .instret_o(instret_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {17'd0, mem_req_o, mem_we_o, addr_sel_o, instr_we_o, pc_we_o, rd_we_o,
              alu_src_a_o, alu_src_b_o, result_sel_o, alu_op_o, illegal_instr_o};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_LUI};
   endfunction

   // Instruction-class timing rules at zero wait.
   function automatic int base_cycles(input logic [6:0] op);
      case (op)
         OP_LW:               return 5;
         OP_SW, OP_R, OP_I:   return 4;
         default:             return 3;
      endcase
   endfunction

   // Called at a negedge with the DUT in FETCH; returns at the negedge where the next FETCH is visible.
   task automatic run_instr(input string nm, input logic [6:0] op, input int fw, input int mw,
                            input logic z, input bit wrap);
      int  cyc = 0, fcnt = 0, mcnt = 0;
      int  n_iwe = 0, n_pcwe = 0, n_rdwe = 0, n_ill = 0, n_we = 0;
      bit  fetch_done = 0, waiting = 0, done = 0;
      bit  is_mem;
      logic rdy, pr_addr, pr_we;
      is_mem   = (op == OP_LW) || (op == OP_SW);
      opcode_i = op;
      zero_i   = z;
      pr_addr  = 1'b0;
      pr_we    = 1'b0;
      chk({nm, "_fetch_start"}, {30'd0, mem_req_o, addr_sel_o}, 32'b10);
      while (!done && cyc < 64) begin
         if (cyc > 0 && fetch_done && mem_req_o && !addr_sel_o) begin
            done = 1;
         end else begin
            if (waiting)
               chk({nm, "_req_hold"}, {29'd0, mem_req_o, addr_sel_o, mem_we_o}, {29'd0, 1'b1, pr_addr, pr_we});
            if (mem_req_o) begin
               if (!addr_sel_o) begin
                  rdy = (fcnt == fw);
                  fcnt++;
                  if (rdy) fetch_done = 1;
               end else begin
                  rdy = (mcnt == mw);
                  mcnt++;
               end
               waiting = !rdy;
               pr_addr = addr_sel_o;
               pr_we   = mem_we_o;
            end else begin
               rdy     = 1'($urandom);
               waiting = 0;
            end
            mem_ready_i = rdy;
            #1;
            n_iwe  += int'(instr_we_o);
            n_pcwe += int'(pc_we_o);
            n_rdwe += int'(rd_we_o);
            n_ill  += int'(illegal_instr_o);
            n_we   += int'(mem_we_o && mem_req_o);
            if (wrap && cyc == 0) begin
               force dut.instret_q = 32'hFFFF_FFFF;
               model_instret = 32'hFFFF_FFFF;
            end
            @(posedge clk_i);
            @(negedge clk_i);
            if (wrap && cyc == 0) begin
               release dut.instret_q;
               #0;
               chk({nm, "_preset"}, instret_o, 32'hFFFF_FFFF);
            end
            cyc++;
         end
      end
      chk({nm, "_done"}, {31'd0, done}, 32'd1);
      chk({nm, "_cycles"}, cyc, base_cycles(op) + fw + (is_mem ? mw : 0));
      chk({nm, "_instr_we"}, n_iwe, 1);
      chk({nm, "_pc_we"}, n_pcwe, 1 + ((op == OP_BEQ && z) ? 1 : 0));
      chk({nm, "_rd_we"}, n_rdwe, (op inside {OP_LW, OP_R, OP_I, OP_LUI}) ? 1 : 0);
      chk({nm, "_illegal"}, n_ill, is_legal(op) ? 0 : 1);
      chk({nm, "_mem_we"}, n_we, (op == OP_SW) ? mw + 1 : 0);
      chk({nm, "_data_acc"}, mcnt, is_mem ? mw + 1 : 0);
      if (is_legal(op)) model_instret = model_instret + 32'd1;
      chk({nm, "_instret"}, instret_o, model_instret);
   endtask

   // Release reset at a negedge; one IDLE cycle precedes the first fetch.
   task automatic release_reset(input string nm);
      rst_i = 1'b0;
      mem_ready_i = 1'b0;
      #1;
      chk({nm, "_idle_req"}, {31'd0, mem_req_o}, 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      chk({nm, "_first_fetch"}, {30'd0, mem_req_o, addr_sel_o}, 32'b10);
      model_instret = 32'd0;
   endtask

   initial begin
      logic [6:0] op;
      logic [6:0] legal_ops [6];
      int         k;
      bit         seen_we;
      legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_LUI};

      repeat (3) @(negedge clk_i);
      chk("reset_outs", all_outs(), 32'd0);
      chk("reset_instret", instret_o, 32'd0);
      release_reset("rel");

      run_instr("addi", OP_I,   0, 0, 1'b0, 0);
      run_instr("add",  OP_R,   0, 0, 1'b0, 0);
      run_instr("lw",   OP_LW,  0, 0, 1'b0, 0);
      run_instr("sw",   OP_SW,  0, 0, 1'b0, 0);
      run_instr("beqt", OP_BEQ, 0, 0, 1'b1, 0);
      run_instr("lui",  OP_LUI, 0, 0, 1'b0, 0);
      chk("prog_instret", instret_o, 32'd6);

      run_instr("lw_wait", OP_LW, 3, 3, 1'b0, 0);
      run_instr("beqn", OP_BEQ, 0, 0, 1'b0, 0);
      run_instr("ill7f", 7'h7F, 0, 0, 1'b0, 0);
      run_instr("wrap", OP_I, 1, 0, 1'b0, 1);
      chk("wrap_zero", instret_o, 32'd0);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            op = 7'($urandom);
            while (is_legal(op)) op = 7'($urandom);
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         run_instr($sformatf("rnd%0d", i), op, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom), 0);
      end

      // Abort a store while it is stalled on memory.
      opcode_i    = OP_SW;
      mem_ready_i = 1'b1;
      seen_we     = 0;
      k           = 0;
      while (!seen_we && k < 12) begin
         @(posedge clk_i);
         @(negedge clk_i);
         seen_we     = mem_req_o && mem_we_o;
         mem_ready_i = !seen_we;
         k++;
      end
      chk("abort_reached_memwr", {31'd0, seen_we}, 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      chk("abort_still_req", {30'd0, mem_req_o, mem_we_o}, 32'b11);
      #2 rst_i = 1'b1;
      #1;
      chk("abort_req_drop", {31'd0, mem_req_o}, 32'd0);
      chk("abort_outs", all_outs(), 32'd0);
      chk("abort_instret", instret_o, 32'd0);
      @(negedge clk_i);
      release_reset("rel2");
      run_instr("post_abort", OP_LUI, 0, 0, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rv_mc_fsm.md
# rv_mc_fsm

Multicycle main controller for the RV32I core. It sequences the shared ALU, register file and the single unified memory port over several cycles per instruction. Each decoded opcode is turned into per-state strobes and mux selects. The block replaces the single-cycle combinational ALU-op generation: its `alu_op_o` feeds the decoder's ALU-control logic with the same 2-bit encoding. It also keeps a retired-instruction counter.

## Interface
Parameters:
- `RESET_VEC_WAIT`, 1: idle cycles after reset release before the first fetch (1..15).

Ports:
- `clk_i` in 1: core clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `opcode_i` in 7: `instr[6:0]` from the instruction register. Valid from DECODE onward.
- `zero_i` in 1: ALU zero flag.
- `mem_ready_i` in 1: memory has accepted or completed the current access this cycle.
- `mem_req_o` out 1: memory access request.
- `mem_we_o` out 1: write request, qualified by `mem_req_o`.
- `addr_sel_o` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `instr_we_o` out 1: load the instruction register and the old-PC register.
- `pc_we_o` out 1: PC write enable.
- `rd_we_o` out 1: register-file write enable.
- `alu_src_a_o` out 2: ALU A select. 0 = PC, 1 = oldPC, 2 = rs1.
- `alu_src_b_o` out 2: ALU B select. 0 = rs2, 1 = immediate, 2 = constant 4.
- `result_sel_o` out 2: result select. 0 = ALUOut, 1 = mem rdata, 2 = ALU result, 3 = U-immediate.
- `alu_op_o` out 2: 00 = add, 01 = sub, 10 = funct-decoded.
- `illegal_instr_o` out 1: one-cycle pulse for an unsupported opcode.
- `instret_o` out 32: count of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BEQ, LUI, TRAP.
- Outputs are Moore-decoded from the state, except the strobes marked "& ready" below.
- Any output not listed for a state is 0.
- IDLE: wait `RESET_VEC_WAIT` cycles using a 4-bit counter, then go to FETCH.
- FETCH: `mem_req_o`=1, `addr_sel_o`=0, `alu_src_a_o`=0, `alu_src_b_o`=2, `alu_op_o`=00, `result_sel_o`=2.
  - `instr_we_o` and `pc_we_o` = `mem_ready_i`.
  - Stay in FETCH while not ready. Go to DECODE on ready.
- DECODE: `alu_src_a_o`=1, `alu_src_b_o`=1, `alu_op_o`=00 (computes the branch target into ALUOut). Next state by `opcode_i`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BEQ
  - 0110111 → LUI
  - anything else → TRAP
- MEMADR: A=2, B=1, op=00. Go to MEMRD if the opcode is lw, otherwise MEMWR.
- MEMRD: `mem_req_o`=1, `addr_sel_o`=1. Hold until ready, then go to MEMWB.
- MEMWB: `rd_we_o`=1, `result_sel_o`=1. Retire, go to FETCH.
- MEMWR: `mem_req_o`=1, `mem_we_o`=1, `addr_sel_o`=1. Hold until ready, then retire and go to FETCH.
- EXEC_R: A=2, B=0, op=10. Go to ALUWB.
- EXEC_I: A=2, B=1, op=10. Go to ALUWB.
- ALUWB: `rd_we_o`=1, `result_sel_o`=0. Retire, go to FETCH.
- BEQ: A=2, B=0, op=01, `result_sel_o`=0, `pc_we_o`=`zero_i`. Retire, go to FETCH.
- LUI: `rd_we_o`=1, `result_sel_o`=3. Retire, go to FETCH.
- TRAP: `illegal_instr_o`=1. No retire, go to FETCH.
- Retire increments `instret_o` by 1 on the leaving clock edge. It wraps from 0xFFFFFFFF to 0 with no flag.
- Once asserted, `mem_req_o`, `mem_we_o` and `addr_sel_o` stay stable until the cycle in which `mem_ready_i`=1.

## Timing
- Reset: state = IDLE, IDLE counter = 0, `instret_o` = 0, all outputs 0.
- Assertion of `rst_i` takes effect immediately, including mid-access.
  - `mem_req_o` drops asynchronously.
  - A pending access is abandoned. No retire is counted.
- After reset release, the first `mem_req_o` appears `RESET_VEC_WAIT` cycles later.
- Minimum cycles per instruction, with zero-wait memory:
  - lw: 5
  - sw, R-type, I-ALU: 4
  - beq, lui: 3
  - illegal: 3
- Each memory wait cycle adds 1 cycle.
- `instret_o` updates the cycle after the retiring state.
- `opcode_i` is sampled only in DECODE and MEMADR. The IR is stable because `instr_we_o` is only asserted in FETCH.
- `mem_ready_i` outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- **Reset and idle.** `RESET_VEC_WAIT`=1. Release reset.
  - IDLE lasts 1 cycle, FETCH follows, `mem_req_o`=1 with `addr_sel_o`=0.
  - All outputs and `instret_o` were 0 during reset.
- **Zero-wait program.** Run addi, add, lw, sw, beq (taken, `zero_i`=1), lui.
  - State traces have 4, 4, 5, 4, 3, 3 cycles.
  - `pc_we_o` is asserted in the BEQ state.
  - `instret_o`=6 at the end.
- **Wait states.** Hold `mem_ready_i`=0 for 3 cycles in FETCH and in MEMRD for a lw.
  - Request and address stay stable throughout.
  - `instr_we_o` pulses exactly once.
  - The lw takes 11 cycles.
- **Not-taken beq.** Run a beq with `zero_i`=0.
  - `pc_we_o`=0 in BEQ.
  - Retires, returns to FETCH.
- **Illegal opcode 0x7F.**
  - `illegal_instr_o` pulses for 1 cycle in TRAP.
  - `instret_o` is unchanged.
  - Next state is FETCH.
- **Reset mid-MEMWR and counter wrap.**
  - Assert `rst_i` while waiting in MEMWR: `mem_req_o` drops immediately and the state returns to IDLE.
  - Force `instret_o`=0xFFFFFFFF, then retire one instruction: `instret_o` reads 0.
